// File: rtl/mnist_pkg.sv
// mnist_pkg: shared network constants and the flatten buffer state encoding.
package mnist_pkg;
  localparam int DEF_CHANNELS = 16;
  localparam int DEF_OUT_W = 5;
  localparam int DEF_OUT_H = 5;
  typedef enum logic {COLLECT, FULL} state_t;
endpackage

// File: rtl/maxpool_flatten_buf.sv
// maxpool_flatten_buf: gathers pooled pixels in raster order into one flat frame for the FC layer.
module maxpool_flatten_buf
  import mnist_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int OUT_W = DEF_OUT_W,
  parameter int OUT_H = DEF_OUT_H
) (
  input  logic clk,
  input  logic rst,
  input  logic [CHANNELS-1:0] pool_in,
  input  logic pool_valid,
  output logic [CHANNELS*OUT_W*OUT_H-1:0] feature_vec,
  output logic feature_valid,
  input  logic feature_ready,
  output logic overflow,
  output logic [$clog2(OUT_W*OUT_H+1)-1:0] pix_count
);
  localparam int PIX = OUT_W * OUT_H;
  localparam int CW = $clog2(PIX + 1);
  state_t state, state_nxt;
  logic cap, accept;
  logic [CW-1:0] wr_idx, count_nxt;
  // a pixel arriving in the accept cycle becomes pixel 0 of the next frame
  always_comb begin
    accept = state == FULL && feature_ready;
    cap = pool_valid && (state == COLLECT || feature_ready);
    wr_idx = state == FULL ? '0 : pix_count;
    count_nxt = accept ? CW'(cap) : state == FULL ? pix_count : pix_count + CW'(cap);
    state_nxt = (cap && wr_idx == CW'(PIX - 1)) ? FULL : accept ? COLLECT : state;
  end
  assign feature_valid = state == FULL;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= COLLECT;
      pix_count <= '0;
      overflow <= 1'b0;
      feature_vec <= '0;
    end else begin
      state <= state_nxt;
      pix_count <= count_nxt;
      if (state == FULL && pool_valid && !feature_ready) overflow <= 1'b1;
      for (int i = 0; i < PIX; i++)
        if (cap && wr_idx == CW'(i)) feature_vec[i*CHANNELS +: CHANNELS] <= pool_in;
    end
endmodule

// File: tb/tb_maxpool_flatten_buf.sv
// tb_maxpool_flatten_buf: directed stimulus with a frame scoreboard checked by an independent monitor.
module tb_maxpool_flatten_buf;
  localparam int VW = 16 * 25;
  logic clk = 0, rst = 1;
  logic [15:0] pool_in = '0;
  logic pool_valid = 0, feature_ready = 0;
  logic [VW-1:0] feature_vec;
  logic feature_valid, overflow;
  logic [4:0] pix_count;
  logic [VW-1:0] mvec = '0;
  logic [VW-1:0] exp_q[$];
  int checks = 0, fails = 0;

  maxpool_flatten_buf dut (
    .clk(clk), .rst(rst), .pool_in(pool_in), .pool_valid(pool_valid),
    .feature_vec(feature_vec), .feature_valid(feature_valid),
    .feature_ready(feature_ready), .overflow(overflow), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input int p, input bit push);
    pool_valid = 1;
    pool_in = d;
    mvec[p*16 +: 16] = d;
    if (push) exp_q.push_back(mvec);
    step();
    pool_valid = 0;
  endtask

  // monitor: every new frame presentation must match the oldest expected frame
  logic prev_valid = 0;
  always @(negedge clk) begin
    if (!rst && feature_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL frame_unexpected: got valid frame %0h, expected none", feature_vec);
      end else chk("frame_data", feature_vec, exp_q.pop_front());
    end
    prev_valid <= feature_valid;
  end

  initial begin
    int vcnt;
    #12 rst = 0;
    #1;
    chk("rst_pix", VW'(pix_count), 0);
    chk("rst_valid", VW'(feature_valid), 0);
    chk("rst_ovf", VW'(overflow), 0);
    chk("rst_vec", feature_vec, '0);
    // 25 consecutive beats
    for (int p = 0; p < 25; p++) begin
      if (p == 24) chk("cons_no_early", VW'(feature_valid), 0);
      beat(16'(p), p, p == 24);
    end
    chk("cons_valid", VW'(feature_valid), 1);
    chk("cons_pix", VW'(pix_count), 25);
    // dropped pixel while FULL
    beat(16'hAAAA, 0, 0);
    mvec[15:0] = 16'h0000;
    chk("ovf_set", VW'(overflow), 1);
    chk("ovf_valid", VW'(feature_valid), 1);
    chk("ovf_vec", feature_vec, mvec);
    step(); step();
    chk("ovf_sticky", VW'(overflow), 1);
    // accept plus simultaneous first pixel of next frame
    feature_ready = 1;
    beat(16'hFFFF, 0, 0);
    feature_ready = 0;
    chk("acc_valid", VW'(feature_valid), 0);
    chk("acc_pix", VW'(pix_count), 1);
    chk("acc_p0", VW'(feature_vec[15:0]), 16'hFFFF);
    for (int p = 1; p < 10; p++) beat(16'h1000 + 16'(p), p, 0);
    chk("mid_pix", VW'(pix_count), 10);
    // asynchronous reset mid-frame
    #2 rst = 1;
    #1;
    chk("arst_pix", VW'(pix_count), 0);
    chk("arst_valid", VW'(feature_valid), 0);
    chk("arst_ovf", VW'(overflow), 0);
    chk("arst_vec", feature_vec, '0);
    #1 rst = 0;
    mvec = '0;
    // gapped frame, valid 1 of 3 cycles
    for (int p = 0; p < 25; p++) begin
      beat(16'(p), p, p == 24);
      if (p < 24)
        for (int g = 0; g < 2; g++) begin
          chk("gap_no_early", VW'(feature_valid), 0);
          step();
        end
    end
    chk("gap_valid", VW'(feature_valid), 1);
    chk("gap_pix", VW'(pix_count), 25);
    feature_ready = 1;
    step();
    chk("gap_acc_valid", VW'(feature_valid), 0);
    chk("gap_acc_pix", VW'(pix_count), 0);
    // back-to-back frames with ready tied high
    vcnt = 0;
    for (int k = 0; k < 50; k++) begin
      beat(16'(k % 25) ^ (k >= 25 ? 16'h5A5A : 16'h0000), k % 25, (k % 25) == 24);
      if (feature_valid) vcnt++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (feature_valid) vcnt++;
    end
    chk("b2b_pulses", VW'(vcnt), 2);
    chk("b2b_ovf", VW'(overflow), 0);
    chk("b2b_pix", VW'(pix_count), 0);
    step();
    chk("queue_empty", VW'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
